// File: rtl/overlay_pkg.sv
// overlay_pkg: shared types and constants for the overlay write scheduler.
// Holds the scheduler FSM encoding, slot index width, grantee ids and the
// cursor blink counter width.
package overlay_pkg;
  localparam int SLOT_W = 3;
  localparam int BLINK_W = 8;
  localparam logic GNT_RTC = 1'b0;
  localparam logic GNT_USR = 1'b1;
  typedef enum logic [1:0] {IDLE, WAIT_VB, ACK} state_t;
endpackage

// File: rtl/overlay_slot_ram.sv
// overlay_slot_ram: resettable slot register file, one write port, one registered read port.
// Ports: clk, rst_n (async active-low); we/wr_slot/wr_code write port;
// rd_slot in, rd_code/rd_oor out one cycle later. Out-of-range slots are
// never written and read back as code 0 with rd_oor high.
module overlay_slot_ram
  import overlay_pkg::*;
#(
  parameter int SLOTS  = 8,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [CODE_W-1:0] wr_code,
  input  logic [SLOT_W-1:0] rd_slot,
  output logic [CODE_W-1:0] rd_code,
  output logic              rd_oor
);
  logic [CODE_W-1:0] r_mem [SLOTS];
  logic [CODE_W-1:0] r_rd_code;
  logic              r_rd_oor;
  logic              w_wr_ok;
  logic              w_rd_ok;
  assign w_wr_ok = 32'(wr_slot) < SLOTS;
  assign w_rd_ok = 32'(rd_slot) < SLOTS;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) r_mem[i] <= '0;
      r_rd_code <= '0;
      r_rd_oor  <= 1'b0;
    end else begin
      if (we && w_wr_ok) r_mem[wr_slot] <= wr_code;
      r_rd_code <= w_rd_ok ? r_mem[rd_slot] : '0;
      r_rd_oor  <= !w_rd_ok;
    end
  end
  assign rd_code = r_rd_code;
  assign rd_oor  = r_rd_oor;
endmodule

// File: rtl/overlay_write_sched.sv
// overlay_write_sched: arbitrates RTC/user character writes, commits them in vblank, serves slot codes.
// Ports: clk, rst_n (async active-low); vblank; rtc_req/slot/code -> rtc_ack;
// usr_req/slot/code -> usr_ack; cursor_en/cursor_slot; rd_slot -> rd_code,
// rd_blank (1-cycle latency); frame_tick pulses on each vblank rising edge.
// Optional OVERLAY_CURSOR_BLINK_EN: blanks the cursor slot every other
// BLINK_FRAMES frames while cursor_en is high.
module overlay_write_sched
  import overlay_pkg::*;
#(
  parameter int SLOTS        = 8,
  parameter int CODE_W       = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              rtc_req,
  input  logic [SLOT_W-1:0] rtc_slot,
  input  logic [CODE_W-1:0] rtc_code,
  output logic              rtc_ack,
  input  logic              usr_req,
  input  logic [SLOT_W-1:0] usr_slot,
  input  logic [CODE_W-1:0] usr_code,
  output logic              usr_ack,
  input  logic              cursor_en,
  input  logic [SLOT_W-1:0] cursor_slot,
  input  logic [SLOT_W-1:0] rd_slot,
  output logic [CODE_W-1:0] rd_code,
  output logic              rd_blank,
  output logic              frame_tick
);
  state_t            r_state;
  logic              r_gnt;
  logic [SLOT_W-1:0] r_slot;
  logic [CODE_W-1:0] r_code;
  logic              r_rtc_ack;
  logic              r_usr_ack;
  logic              r_vb;
  logic              r_tick;
  logic              w_pick;
  logic              w_we;
  logic              w_oor;
  // r_gnt doubles as last_grant: on a tie the side not served last wins
  assign w_pick = (rtc_req && usr_req) ? !r_gnt : (usr_req ? GNT_USR : GNT_RTC);
  assign w_we   = (r_state == WAIT_VB) && vblank;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= GNT_RTC;
      r_slot    <= '0;
      r_code    <= '0;
      r_rtc_ack <= 1'b0;
      r_usr_ack <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (rtc_req || usr_req) begin
          r_gnt   <= w_pick;
          r_slot  <= (w_pick == GNT_USR) ? usr_slot : rtc_slot;
          r_code  <= (w_pick == GNT_USR) ? usr_code : rtc_code;
          r_state <= WAIT_VB;
        end
        WAIT_VB: if (vblank) begin
          r_rtc_ack <= r_gnt == GNT_RTC;
          r_usr_ack <= r_gnt == GNT_USR;
          r_state   <= ACK;
        end
        default: begin
          r_rtc_ack <= 1'b0;
          r_usr_ack <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vb   <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_vb   <= vblank;
      r_tick <= vblank && !r_vb;
    end
  end
  overlay_slot_ram #(.SLOTS(SLOTS), .CODE_W(CODE_W)) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (w_we),
    .wr_slot(r_slot),
    .wr_code(r_code),
    .rd_slot(rd_slot),
    .rd_code(rd_code),
    .rd_oor (w_oor)
  );
`ifdef OVERLAY_CURSOR_BLINK_EN
  logic [BLINK_W-1:0] r_cnt;
  logic               r_blink_off;
  logic [SLOT_W-1:0]  r_rd_slot;
  logic               w_wrap;
  assign w_wrap = r_cnt == BLINK_W'(BLINK_FRAMES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_blink_off <= 1'b0;
      r_rd_slot   <= '0;
    end else begin
      r_rd_slot <= rd_slot;
      if (!cursor_en) begin
        r_cnt       <= '0;
        r_blink_off <= 1'b0;
      end else if (r_tick) begin
        r_cnt       <= w_wrap ? '0 : r_cnt + 1'b1;
        r_blink_off <= r_blink_off ^ w_wrap;
      end
    end
  end
  // r_rd_slot keeps the cursor compare aligned with the registered read data
  assign rd_blank = w_oor || (cursor_en && r_blink_off && r_rd_slot == cursor_slot);
`else
  logic w_unused;
  assign w_unused = &{1'b0, cursor_en, cursor_slot};
  assign rd_blank = w_oor;
`endif
  assign rtc_ack    = r_rtc_ack;
  assign usr_ack    = r_usr_ack;
  assign frame_tick = r_tick;
endmodule

// File: doc/overlay_write_sched.md
# overlay_write_sched

Write scheduler and slot store for the on-screen character overlay. Arbitrates character updates from the RTC reader and from the user edit path, commits them only during vertical blanking so a frame never shows a half-updated time field, and serves the stored character code per slot to the overlay renderer with an optional blinking edit cursor. It sits between the RTC/keypad control logic and the character ROM lookup in the VGA path.

## Interface
- SLOTS, 8: number of character slots on screen (max 8).
- CODE_W, 4: width of a character code (ROM object index).
- BLINK_FRAMES, 30: frames per cursor blink half-period (1..255).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- vblank  in  1  high while the sync generator is in vertical blanking.
- rtc_req  in  1  RTC update request, held high until acked.
- rtc_slot  in  3  target slot of RTC update.
- rtc_code  in  CODE_W  character code of RTC update.
- rtc_ack  out  1  one-cycle pulse: RTC update completed.
- usr_req  in  1  user edit request, held high until acked.
- usr_slot  in  3  target slot of user edit.
- usr_code  in  CODE_W  character code of user edit.
- usr_ack  out  1  one-cycle pulse: user edit completed.
- cursor_en  in  1  edit mode active; enables cursor blink.
- cursor_slot  in  3  slot under the edit cursor.
- rd_slot  in  3  slot currently being drawn by the renderer.
- rd_code  out  CODE_W  code stored in rd_slot, one cycle later.
- rd_blank  out  1  renderer must draw background for this slot.
- frame_tick  out  1  one-cycle pulse on each vblank rising edge.

## Operation
- FSM states: IDLE, WAIT_VB, ACK. Reset state IDLE.
- IDLE: if any req high, grant one, latch its slot/code and grantee id, go WAIT_VB. No req: stay.
- Arbitration: round-robin on last_grant bit; both requesting -> the one not granted last wins; single requester always wins. last_grant resets to RTC (usr wins first tie).
- WAIT_VB: when vblank=1, write latched code into slot at that edge, go ACK. Otherwise hold; latched values unaffected by req/slot/code changes.
- ACK: grantee's ack high for exactly this cycle; next edge -> IDLE. Requester deasserts req at the edge ending the ack cycle; req still high in IDLE is a new request.
- Latched slot >= SLOTS: no write, still acked (no deadlock).
- Slot store: SLOTS x CODE_W registers, all reset to 0.
- Read: rd_code registered from rd_slot; rd_slot >= SLOTS -> rd_code=0, rd_blank=1.
- frame_tick: vblank registered, pulse when vblank=1 and previous=0.
- Reset mid-operation: FSM to IDLE, latched request discarded, acks 0, store cleared; a still-high req is re-granted after reset.
- Outputs at reset: rtc_ack=0, usr_ack=0, rd_code=0, rd_blank=0, frame_tick=0.

## Timing
- Request to ack, vblank already high: req seen at edge E0 (IDLE->WAIT_VB), write at E1, ack high during cycle E1..E2. Ack visible 2 cycles after req sampled.
- vblank low: ack follows 1 cycle after the first edge with vblank=1.
- Written code visible on rd_code at the read issued the cycle after the write edge.
- Read latency 1 cycle; rd_blank aligned with rd_code.
- Only one write per 3 cycles; throughput bounded by FSM, not by vblank count.

## Configuration
- OVERLAY_CURSOR_BLINK_EN defined: 8-bit frame counter counts frame_tick; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_off (reset 0). rd_blank additionally high when cursor_en=1, blink_off=1 and registered rd_slot==cursor_slot. cursor_en=0 clears counter and blink_off.
- Undefined: no counter; cursor_en/cursor_slot ignored; rd_blank only for out-of-range slots.

## Structure
- Package overlay_pkg: FSM state encoding, SLOT_W=3, grantee id constants (GNT_RTC, GNT_USR), blink counter width.
- Sub-module overlay_slot_ram: resettable slot register file with one write port and one registered read port, including out-of-range handling.

## Test plan
- Reset, vblank=1, usr_req slot 2 code 5 -> usr_ack pulse 2 cycles later; rd_slot=2 then rd_code=5.
- vblank=0, rtc_req slot 0 code 9; raise vblank after 100 cycles -> no write and no ack before vblank; rtc_ack 1 cycle after vblank rises.
- Both req simultaneously, held, vblank=1 -> usr granted first, rtc second; acks never overlap; third tie goes to usr.
- usr_req slot 7 with SLOTS=6 -> usr_ack pulses, store unchanged; rd_slot=7 -> rd_code=0, rd_blank=1.
- Assert rst_n=0 while in WAIT_VB -> ack never issued, store all 0; req still high after release -> granted and acked normally.
- Macro on, BLINK_FRAMES=2, cursor_en=1, cursor_slot=3 -> rd_blank for slot 3 toggles every 2 frame_tick pulses; slot 4 never blank.
